// File: rtl/pulse_meter_pkg.sv
// Shared types and default constants for the pulse period meter.
package pulse_meter_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAcquire,
      StLocked
   } pm_state_e;

   localparam logic [7:0]  PM_HI_TH   = 8'hC0;
   localparam logic [7:0]  PM_LO_TH   = 8'h40;
   localparam int unsigned PM_TIMEOUT = 32'd16777216;

endpackage

// File: rtl/level_slicer.sv
// Hysteresis slicer: turns 8-bit samples into a binary level and flags level changes
// combinationally in the cycle the new level is presented.
module level_slicer
   import pulse_meter_pkg::*;
#(
   parameter logic [7:0] HI_TH = PM_HI_TH,
   parameter logic [7:0] LO_TH = PM_LO_TH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   output logic       lvl,
   output logic       lvl_edge
);

   logic lvl_n, lvl_q;

   // Samples strictly between the thresholds keep the previous level.
   always_comb begin
      lvl_n = lvl_q;
      if (data >= HI_TH) begin
         lvl_n = 1'b1;
      end else if (data <= LO_TH) begin
         lvl_n = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q <= 1'b0;
      end else begin
         lvl_q <= lvl_n;
      end
   end

   assign lvl      = lvl_q;
   assign lvl_edge = (lvl_n != lvl_q);

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the half-period of a sliced pulse waveform, reports count_max per edge,
// declares lock after repeated agreement and flags loss of signal.
module pulse_period_meter
   import pulse_meter_pkg::*;
#(
   parameter int unsigned CNT_W      = 32,
   parameter logic [7:0]  HI_TH      = PM_HI_TH,
   parameter logic [7:0]  LO_TH      = PM_LO_TH,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned TOL        = 0,
   parameter int unsigned TIMEOUT    = PM_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       data,
   output logic [CNT_W-1:0] count_max,
   output logic             valid,
   output logic             locked,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] Tol      = CNT_W'(TOL);
   localparam logic [3:0]       LockCnt  = 4'(LOCK_COUNT);

   logic             lvl_edge, lvl_unused;
   logic [CNT_W-1:0] cnt_q, ref_q, count_max_q, diff;
   logic [3:0]       match_q;
   logic             valid_q, locked_q, timeout_q, mismatch;
   pm_state_e        state_q;

   level_slicer #(
      .HI_TH (HI_TH),
      .LO_TH (LO_TH)
   ) u_slicer (
      .clk      (clk),
      .rst_n    (rst_n),
      .data     (data),
      .lvl      (lvl_unused),
      .lvl_edge (lvl_edge)
   );

   // Larger operand first so the difference never wraps.
   assign diff     = (cnt_q >= ref_q) ? (cnt_q - ref_q) : (ref_q - cnt_q);
   assign mismatch = (diff > Tol);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (lvl_edge) begin
         cnt_q <= '0;
      end else if (cnt_q != CntLimit) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         match_q     <= '0;
         ref_q       <= '0;
         count_max_q <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (lvl_edge) begin
            // An edge beats a simultaneous timeout.
            timeout_q <= 1'b0;
            unique case (state_q)
               StIdle: begin
                  state_q <= StAcquire;
                  match_q <= '0;
               end
               StAcquire: begin
                  count_max_q <= cnt_q;
                  valid_q     <= 1'b1;
                  ref_q       <= cnt_q;
                  if (match_q == 4'd0 || mismatch) begin
                     match_q <= 4'd1;
                  end else begin
                     match_q <= match_q + 4'd1;
                     if (match_q + 4'd1 == LockCnt) begin
                        state_q  <= StLocked;
                        locked_q <= 1'b1;
                     end
                  end
               end
               StLocked: begin
                  count_max_q <= cnt_q;
                  valid_q     <= 1'b1;
                  ref_q       <= cnt_q;
                  if (mismatch) begin
                     state_q  <= StAcquire;
                     match_q  <= 4'd1;
                     locked_q <= 1'b0;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end else if (cnt_q == CntLimit) begin
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            state_q   <= StIdle;
            match_q   <= '0;
         end
      end
   end

   assign count_max = count_max_q;
   assign valid     = valid_q;
   assign locked    = locked_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench: two meter instances (TOL=1/TIMEOUT=64 and all defaults) fed the same
// randomized waveforms and compared every cycle against an edge-timestamp reference model.
module tb_pulse_period_meter;

   localparam longint TmoA = 64;
   localparam longint TmoB = 16777216;

   logic        clk, rst_n;
   logic [7:0]  data;
   logic [15:0] ca_cm;
   logic        ca_v, ca_l, ca_t;
   logic [31:0] cb_cm;
   logic        cb_v, cb_l, cb_t;

   int n_chk, n_pass, n_fail;

   // Reference model state, one slot per instance.
   logic   m_lvl[2];
   longint m_last[2];
   bit     m_active[2];
   int     m_match[2];
   longint m_ref[2];
   longint m_cm[2];
   bit     m_valid[2], m_locked[2], m_tmo[2];
   longint cyc;
   bit     cur_hi;

   pulse_period_meter #(
      .CNT_W      (16),
      .LOCK_COUNT (4),
      .TOL        (1),
      .TIMEOUT    (64)
   ) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (data),
      .count_max (ca_cm),
      .valid     (ca_v),
      .locked    (ca_l),
      .timeout   (ca_t)
   );

   pulse_period_meter dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (data),
      .count_max (cb_cm),
      .valid     (cb_v),
      .locked    (cb_l),
      .timeout   (cb_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint p_tmo(int k);
      return (k == 0) ? TmoA : TmoB;
   endfunction

   function automatic longint p_tol(int k);
      return (k == 0) ? 64'd1 : 64'd0;
   endfunction

   task automatic mdl_reset();
      for (int k = 0; k < 2; k++) begin
         m_lvl[k] = 1'b0; m_last[k] = -1; m_active[k] = 0; m_match[k] = 0;
         m_ref[k] = 0; m_cm[k] = 0; m_valid[k] = 0; m_locked[k] = 0; m_tmo[k] = 0;
      end
      cyc = 0;
   endtask

   // Edge times drive everything: a measurement is the gap between edges minus one.
   function automatic void mdl_step(int k, logic [7:0] d);
      logic   nl;
      longint el, m, df;
      nl = (d >= 8'hC0) ? 1'b1 : (d <= 8'h40) ? 1'b0 : m_lvl[k];
      el = cyc - m_last[k] - 1;
      m  = (el < p_tmo(k) - 1) ? el : p_tmo(k) - 1;
      m_valid[k] = 0;
      if (nl != m_lvl[k]) begin
         if (!m_active[k]) begin
            m_active[k] = 1;
            m_match[k]  = 0;
         end else begin
            df = (m > m_ref[k]) ? m - m_ref[k] : m_ref[k] - m;
            m_cm[k] = m;
            m_valid[k] = 1;
            if (m_locked[k]) begin
               if (df > p_tol(k)) begin
                  m_locked[k] = 0;
                  m_match[k]  = 1;
               end
            end else begin
               m_match[k] = (m_match[k] == 0 || df > p_tol(k)) ? 1 : m_match[k] + 1;
               if (m_match[k] == 4) m_locked[k] = 1;
            end
            m_ref[k] = m;
         end
         m_tmo[k]  = 0;
         m_last[k] = cyc;
      end else if (el >= p_tmo(k) - 1) begin
         m_tmo[k] = 1; m_locked[k] = 0; m_active[k] = 0;
      end
      m_lvl[k] = nl;
   endfunction

   task automatic check_all();
      chk("A.count_max", 64'(ca_cm), m_cm[0]);
      chk("A.valid", 64'(ca_v), 64'(m_valid[0]));
      chk("A.locked", 64'(ca_l), 64'(m_locked[0]));
      chk("A.timeout", 64'(ca_t), 64'(m_tmo[0]));
      chk("B.count_max", 64'(cb_cm), m_cm[1]);
      chk("B.valid", 64'(cb_v), 64'(m_valid[1]));
      chk("B.locked", 64'(cb_l), 64'(m_locked[1]));
      chk("B.timeout", 64'(cb_t), 64'(m_tmo[1]));
   endtask

   task automatic tick(input logic [7:0] d);
      data = d;
      @(posedge clk);
      mdl_step(0, d);
      mdl_step(1, d);
      cyc++;
      @(negedge clk);
      check_all();
   endtask

   function automatic logic [7:0] rnd_sample(bit hi, bit first);
      if (!first && $urandom_range(0, 3) == 0) return 8'($urandom_range(8'h41, 8'hBF));
      return hi ? 8'($urandom_range(8'hC0, 8'hFF)) : 8'($urandom_range(8'h00, 8'h40));
   endfunction

   task automatic wave(input int half, input int n);
      for (int h = 0; h < n; h++) begin
         cur_hi = !cur_hi;
         for (int i = 0; i < half; i++) tick(rnd_sample(cur_hi, i == 0));
      end
   endtask

   task automatic wave_alt(input int a, input int b, input int n);
      for (int h = 0; h < n; h++) begin
         cur_hi = !cur_hi;
         for (int i = 0; i < ((h % 2 == 0) ? a : b); i++) tick(rnd_sample(cur_hi, i == 0));
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".A.count_max"}, 64'(ca_cm), 64'd0);
      chk({tag, ".A.valid"}, 64'(ca_v), 64'd0);
      chk({tag, ".A.locked"}, 64'(ca_l), 64'd0);
      chk({tag, ".A.timeout"}, 64'(ca_t), 64'd0);
      chk({tag, ".B.count_max"}, 64'(cb_cm), 64'd0);
      chk({tag, ".B.locked"}, 64'(cb_l), 64'd0);
   endtask

   initial begin
      logic [7:0] ramp [7];
      ramp = '{8'h00, 8'h80, 8'hBF, 8'hC0, 8'h90, 8'h41, 8'h40};
      n_chk = 0; n_pass = 0; n_fail = 0;
      cur_hi = 0;
      rst_n = 1'b0;
      data  = 8'h00;
      mdl_reset();
      #23 check_zero("reset");
      #4 rst_n = 1'b1;

      // Idle low, then a 10-cycle half-period square wave.
      for (int i = 0; i < 5; i++) tick(8'h00);
      wave(10, 8);
      chk("sq10.A.count_max", 64'(ca_cm), 64'd9);
      chk("sq10.B.locked", 64'(cb_l), 64'd1);

      // Half-period change to 21.
      wave(21, 6);
      chk("sq21.B.count_max", 64'(cb_cm), 64'd20);

      // Alternating 9/10 measurements, then a 12.
      wave(10, 5);
      wave_alt(10, 11, 8);
      chk("alt.A.locked", 64'(ca_l), 64'd1);
      wave(13, 1);
      wave(10, 1);
      chk("jump12.A.count_max", 64'(ca_cm), 64'd12);
      chk("jump12.A.locked", 64'(ca_l), 64'd0);

      // Relock, then hold high until loss of signal.
      wave(10, 6);
      cur_hi = 1;
      for (int i = 0; i < 70; i++) tick(8'hFF);
      chk("hold.A.timeout", 64'(ca_t), 64'd1);
      chk("hold.A.locked", 64'(ca_l), 64'd0);
      chk("hold.A.count_max", 64'(ca_cm), 64'd9);
      wave(10, 5);

      // Hysteresis ramp: edges only at 0xC0 and 0x40.
      for (int j = 0; j < 7; j++) begin
         for (int i = 0; i < 3; i++) begin
            tick(ramp[j]);
            chk("ramp.A.valid", 64'(ca_v), 64'((i == 0) && (j == 3 || j == 6)));
         end
      end
      cur_hi = 0;

      // Minimum period: an edge every cycle.
      wave(1, 12);
      chk("min.B.count_max", 64'(cb_cm), 64'd0);
      chk("min.B.valid", 64'(cb_v), 64'd1);

      // Edge coinciding with the timeout limit, then one cycle past it.
      wave(64, 3);
      wave(65, 3);

      // Randomized half-periods, some with jitter.
      for (int r = 0; r < 8; r++) begin
         int h;
         h = int'($urandom_range(1, 30));
         if (r % 2 == 0) wave(h, int'($urandom_range(2, 7)));
         else wave_alt(h, h + 1, int'($urandom_range(3, 8)));
      end

      // Asynchronous reset in the middle of lock.
      wave(10, 8);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_zero("async_rst");
      data = 8'h00;
      cur_hi = 0;
      #20 rst_n = 1'b1;
      mdl_reset();
      wave(10, 8);
      chk("reacq.A.locked", 64'(ca_l), 64'd1);
      chk("reacq.B.count_max", 64'(cb_cm), 64'd9);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
